// File: rtl/median_store_ctrl.sv
// median_store_ctrl: fill/drain sequencer for one median-result tile BRAM.
// Define MEDIAN_STORE_TILE_CNT_EN to add the o_tile_cnt completed-tile counter.
module median_store_ctrl #(
  parameter  int WIDTH  = 8,
  parameter  int FILTER = 5,
  localparam int DEPTH  = (2*FILTER)*(2*FILTER),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_med_valid,
  input  logic [WIDTH-1:0] i_med_data,
  output logic             o_med_ready,
  output logic             o_wren,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_din,
  output logic [AW-1:0]    o_raddr,
  input  logic [WIDTH-1:0] i_dout,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_busy
`ifdef MEDIAN_STORE_TILE_CNT_EN
  ,
  output logic [15:0]      o_tile_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_R = (AW+1)'(DEPTH);
  state_t                    state_q, state_d;
  logic [AW-1:0]             wcnt_q, wcnt_d, out_cnt_q, out_cnt_d, waddr_q, waddr_d;
  logic [AW:0]               rcnt_q, rcnt_d;
  logic                      wren_q, wren_d, inf_q, inf_d;
  logic [WIDTH-1:0]          din_q, din_d;
  logic [1:0][WIDTH-1:0]     fifo_q, fifo_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      acc, hs, issue, pop, push, po, done;
  assign o_med_ready = state_q == FILL;
  assign acc         = i_med_valid & o_med_ready;
  // The in-flight word is presented straight from i_dout when the FIFO is empty.
  assign o_valid     = (cnt_q != 2'd0) | inf_q;
  assign o_data      = cnt_q != 2'd0 ? fifo_q[0] : inf_q ? i_dout : '0;
  assign o_last      = o_valid & (out_cnt_q == LAST);
  assign hs          = o_valid & i_ready;
  // A pending write (always true on the first DRAIN cycle) delays the first read.
  assign issue       = state_q == DRAIN & !wren_q & (cnt_q + {1'b0, inf_q} < 2'd2) & (rcnt_q < DEPTH_R);
  assign pop         = hs & (cnt_q != 2'd0);
  assign push        = inf_q & !(hs & cnt_q == 2'd0);
  assign po          = cnt_q[1] | (cnt_q[0] & !pop);
  assign done        = i_flush | (hs & out_cnt_q == LAST);
  assign o_wren      = wren_q;
  assign o_waddr     = waddr_q;
  assign o_din       = din_q;
  assign o_raddr     = issue ? rcnt_q[AW-1:0] : '0;
  assign o_busy      = state_q != IDLE;
  always_comb begin
    state_d   = state_q == IDLE & i_med_valid ? FILL : state_q;
    state_d   = acc & wcnt_q == LAST ? DRAIN : state_d;
    state_d   = done ? IDLE : state_d;
    wren_d    = acc & !i_flush;
    waddr_d   = acc ? wcnt_q : waddr_q;
    din_d     = acc ? i_med_data : din_q;
    wcnt_d    = acc ? (wcnt_q == LAST ? '0 : wcnt_q + 1'b1) : wcnt_q;
    rcnt_d    = rcnt_q + {{AW{1'b0}}, issue};
    inf_d     = issue;
    out_cnt_d = hs ? out_cnt_q + 1'b1 : out_cnt_q;
    cnt_d     = cnt_q - {1'b0, pop} + {1'b0, push};
    fifo_d    = fifo_q;
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[po] = i_dout;
    if (done) begin
      wcnt_d    = '0;
      rcnt_d    = '0;
      out_cnt_d = '0;
      inf_d     = 1'b0;
      cnt_d     = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      out_cnt_q <= '0;
      waddr_q   <= '0;
      din_q     <= '0;
      wren_q    <= 1'b0;
      inf_q     <= 1'b0;
      cnt_q     <= '0;
      fifo_q    <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      out_cnt_q <= out_cnt_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      wren_q    <= wren_d;
      inf_q     <= inf_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
    end
  end
`ifdef MEDIAN_STORE_TILE_CNT_EN
  logic [15:0] tile_cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tile_cnt_q <= '0;
    else if (hs & out_cnt_q == LAST & !i_flush) tile_cnt_q <= tile_cnt_q + 16'd1;
  end
  assign o_tile_cnt = tile_cnt_q;
`endif
endmodule

// File: tb/tb_median_store_ctrl.sv
// tb_median_store_ctrl: directed fill/drain, backpressure, hold-off and flush
// vectors against a negedge-write, registered-read BRAM model.
module tb_median_store_ctrl;
  logic       clk = 0, rst_n = 0, flush = 0, med_valid = 0, ready = 1;
  logic [7:0] med_data = 0, dout = 0, din, data;
  logic       med_ready, wren, valid, last, busy;
  logic [6:0] waddr, raddr;
`ifdef MEDIAN_STORE_TILE_CNT_EN
  logic [15:0] tile_cnt;
`endif
  logic [7:0] mem [0:99] = '{default: 8'hC3};
  int         n_chk = 0, n_fail = 0, cyc = 0, fv_cyc = -1;
  int         wren_cnt = 0, stab_err = 0, raddr_err = 0, rdy_pct = 100;
  logic       pend = 0, pend_l = 0;
  logic [7:0] pend_d = 0;
  logic [7:0] exp_q[$], od_q[$], wd_q[$];
  logic [6:0] wa_q[$];
  logic       ol_q[$];
  int         oc_q[$], wc_q[$];

  median_store_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_med_valid(med_valid), .i_med_data(med_data), .o_med_ready(med_ready),
    .o_wren(wren), .o_waddr(waddr), .o_din(din), .o_raddr(raddr), .i_dout(dout),
    .o_valid(valid), .o_data(data), .o_last(last), .i_ready(ready), .o_busy(busy)
`ifdef MEDIAN_STORE_TILE_CNT_EN
    , .o_tile_cnt(tile_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 ready = $urandom_range(99) < rdy_pct;
  end
  always @(posedge clk) dout <= mem[raddr];
  always @(negedge clk) if (wren) mem[waddr] <= din;

  always @(negedge clk) begin
    if (wren) begin
      wren_cnt++;
      wa_q.push_back(waddr);
      wd_q.push_back(din);
      wc_q.push_back(cyc);
    end
    if (raddr > 7'd99) raddr_err++;
    if (valid && fv_cyc < 0) fv_cyc = cyc;
    if (pend && (!valid || data != pend_d || last != pend_l)) stab_err++;
    if (valid && ready && !flush) begin
      od_q.push_back(data);
      ol_q.push_back(last);
      oc_q.push_back(cyc);
    end
    pend   = valid && !ready && !flush;
    pend_d = data;
    pend_l = last;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    exp_q.delete(); od_q.delete(); ol_q.delete(); oc_q.delete();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    fv_cyc = -1;
  endtask

  task automatic send(input logic [7:0] d);
    int k;
    med_valid = 1;
    med_data  = d;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (med_ready) break;
    end
    if (k >= 4000) chk("send_timeout", k, 0);
    @(posedge clk);
    #1 med_valid = 0;
  endtask

  task automatic feed(input int mul, input int off, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'(i * mul + off);
      exp_q.push_back(v);
      send(v);
    end
  endtask

  task automatic wait_idle(output int c);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k >= 4000) chk("idle_timeout", k, 0);
    c = cyc;
  endtask

  task automatic verify(input string tag);
    int we = 0, oe = 0;
    chk({tag, "_nwr"}, wa_q.size(), exp_q.size());
    chk({tag, "_nout"}, od_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < wa_q.size() && (wa_q[i] != 7'(i) || wd_q[i] != exp_q[i])) we++;
      if (i < od_q.size() && (od_q[i] != exp_q[i] || ol_q[i] != (i == 99))) oe++;
    end
    chk({tag, "_wr"}, we, 0);
    chk({tag, "_out"}, oe, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t1, e;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {med_ready, wren, valid, last, busy}, 0);
    chk("rst_addr", {waddr, raddr}, 0);
    chk("rst_data", {din, data}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", med_ready, 0);
    chk("idle_wren", wren_cnt, 0);

    clr();
    feed(1, 0, 100);
    wait_idle(t1);
    verify("t1");
    chk("t1_lat", fv_cyc - wc_q[99], 2);
    chk("t1_rate", oc_q[99] - oc_q[0], 99);
    chk("t1_idle", t1 - oc_q[99], 1);

    rdy_pct = 30;
    clr();
    feed(7, 3, 100);
    wait_idle(t1);
    verify("bp");
    chk("bp_stable", stab_err, 0);
    rdy_pct = 100;

    clr();
    feed(3, 200, 100);
    send(8'hAA);
    chk("hold_drained", od_q.size(), 100);
    verify("t3");
    clr();
    exp_q.push_back(8'hAA);
    feed(5, 1, 99);
    wait_idle(t1);
    verify("hold");

    clr();
    feed(1, 50, 40);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("fl1_busy", busy, 0);
    chk("fl1_wren", wren, 0);
    chk("fl1_nwr", wa_q.size(), 40);
    clr();
    feed(9, 4, 100);
    wait_idle(t1);
    verify("fl1_next");

    clr();
    feed(11, 2, 100);
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (od_q.size() >= 10) break;
    end
    if (k >= 4000) chk("fl2_timeout", k, 0);
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("fl2_busy", busy, 0);
    chk("fl2_valid", {valid, last}, 0);
    e = 0;
    foreach (od_q[i]) if (od_q[i] != exp_q[i]) e++;
    chk("fl2_prefix", e, 0);
    clr();
    feed(1, 0, 100);
    wait_idle(t1);
    verify("fl2_next");

    chk("raddr_range", raddr_err, 0);
`ifdef MEDIAN_STORE_TILE_CNT_EN
    chk("tile_cnt", tile_cnt, 6);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
